// File: rtl/pwm_pkg.sv
// Shared types and constants for the complementary PWM power stage.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_e;

    localparam int CTRL_W   = 10;
    localparam int DUTY_MID = 512;
    localparam int DUTY_MAX = 1023;

endpackage

// File: rtl/pwm_deadband.sv
// Dead-time inserter: turns the raw PWM level into a non-overlapping
// high-side/low-side gate pair with a programmable dead band.
module pwm_deadband #(
    parameter int DEAD_TIME = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic force_off,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam int DW = $clog2(DEAD_TIME + 1);
    localparam logic [DW-1:0] DT = DW'(DEAD_TIME);

    logic          raw_q, raw_d;
    logic          hi_q, hi_d;
    logic          lo_q, lo_d;
    logic [DW-1:0] dead_q, dead_d;

    // Force-off also reloads the dead band so a restart never skips it.
    always_comb begin
        raw_d  = raw;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dead_d = dead_q;
        if (force_off || (raw != raw_q)) begin
            hi_d   = 1'b0;
            lo_d   = 1'b0;
            dead_d = DT;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
            if (dead_q == DW'(1)) begin
                hi_d = raw;
                lo_d = ~raw;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q  <= 1'b0;
            hi_q   <= 1'b0;
            lo_q   <= 1'b0;
            dead_q <= '0;
        end else begin
            raw_q  <= raw_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dead_q <= dead_d;
        end
    end

    assign pwm_hi = hi_q & ~force_off;
    assign pwm_lo = lo_q & ~force_off;

endmodule

// File: rtl/pwm_power_stage.sv
// Complementary PWM power stage: signed control to duty conversion with
// period-boundary shadow latching, soft-start ramp and latched fault shutdown.
module pwm_power_stage
    import pwm_pkg::*;
#(
    parameter int CNT_W     = CTRL_W,
    parameter int PRESCALE  = 1,
    parameter int DEAD_TIME = 4,
    parameter int SS_STEP   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic [CNT_W-1:0] ctrl_in,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [CNT_W-1:0] duty,
    output logic [1:0]       state,
    output logic             fault_latched
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] ss_limit_q, ss_limit_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             period_start_q, period_start_d;

    logic [CNT_W-1:0] duty_req, limit_next, req_capped;
    logic [CNT_W:0]   ss_sum;
    logic             running, go, tick, wrap, raw;

    // Offset-binary conversion: flipping the sign bit adds half scale.
    assign duty_req   = {~ctrl_in[CNT_W-1], ctrl_in[CNT_W-2:0]};
    assign running    = (state_q == SOFTSTART) || (state_q == RUN);
    assign go         = running && enable && !fault;
    assign tick       = (presc_q == PRE_LAST);
    assign wrap       = go && tick && (cnt_q == CNT_MAX);
    assign ss_sum     = {1'b0, ss_limit_q} + (CNT_W+1)'(SS_STEP);
    assign limit_next = ss_sum[CNT_W] ? CNT_MAX : ss_sum[CNT_W-1:0];
    assign req_capped = (duty_req < limit_next) ? duty_req : limit_next;

    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE:      if (enable) state_d = SOFTSTART;
                SOFTSTART: begin
                    if (!enable)
                        state_d = IDLE;
                    else if (wrap && (limit_next == CNT_MAX))
                        state_d = RUN;
                end
                RUN:       if (!enable) state_d = IDLE;
                FAULT:     if (fault_clr) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // The soft-start cap applied at a wrap is the already-raised limit.
    always_comb begin
        presc_d        = presc_q;
        cnt_d          = cnt_q;
        duty_d         = duty_q;
        ss_limit_d     = ss_limit_q;
        period_start_d = 1'b0;
        if (go) begin
            presc_d = tick ? '0 : presc_q + PRE_W'(1);
            if (tick)
                cnt_d = cnt_q + CNT_W'(1);
            if (wrap) begin
                period_start_d = 1'b1;
                if (state_q == SOFTSTART) begin
                    ss_limit_d = limit_next;
                    duty_d     = req_capped;
                end else begin
                    duty_d     = duty_req;
                end
            end
        end
        if ((state_d == IDLE) || (state_d == FAULT)) begin
            presc_d    = '0;
            cnt_d      = '0;
            duty_d     = '0;
            ss_limit_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            duty_q         <= '0;
            ss_limit_q     <= '0;
            presc_q        <= '0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            ss_limit_q     <= ss_limit_d;
            presc_q        <= presc_d;
            period_start_q <= period_start_d;
        end
    end

    assign raw = (cnt_q < duty_q);

    // Anything other than an active, fault-free run gates the drivers off at once.
    pwm_deadband #(
        .DEAD_TIME (DEAD_TIME)
    ) u_deadband (
        .clk       (clk),
        .reset     (reset),
        .raw       (raw),
        .force_off (!go),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo)
    );

    assign period_start  = period_start_q;
    assign duty          = duty_q;
    assign state         = state_q;
    assign fault_latched = (state_q == FAULT);

endmodule

// File: tb/tb_pwm_power_stage.sv
// Directed-plus-random bench for pwm_power_stage against a period-level
// model of duty latching, soft-start ramp and dead-time gate widths.
module tb_pwm_power_stage;

    localparam int DEAD_TIME = 4;
    localparam int SS_STEP   = 256;
    localparam int PERIOD    = 1024;
    localparam int DMAX      = 1023;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       fault;
    logic       fault_clr;
    logic [9:0] ctrl_in;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;
    logic [9:0] duty;
    logic [1:0] state;
    logic       fault_latched;

    int checks = 0;
    int errors = 0;

    pwm_power_stage #(
        .CNT_W     (10),
        .PRESCALE  (1),
        .DEAD_TIME (DEAD_TIME),
        .SS_STEP   (SS_STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .ctrl_in       (ctrl_in),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .period_start  (period_start),
        .duty          (duty),
        .state         (state),
        .fault_latched (fault_latched)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input int c, input logic flt, input logic clr);
        enable    = en;
        ctrl_in   = c[9:0];
        fault     = flt;
        fault_clr = clr;
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((period_start !== 1'b1) && (n < 2 * PERIOD + 16));
        check_output("ps_seen", 32'(period_start), 32'd1);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max0(input int a);
        return (a > 0) ? a : 0;
    endfunction

    // Start must be the first SOFTSTART cycle or a period_start cycle.
    task automatic run_softstart(input int req);
        int lim;
        int n;
        int guard;
        lim   = 0;
        guard = 0;
        while ((lim < DMAX) && (guard < 8)) begin
            guard++;
            wait_ps(n);
            check_output("ss_period", n, PERIOD);
            lim = min2(lim + SS_STEP, DMAX);
            check_output("ss_duty", 32'(duty), min2(req, lim));
            check_output("ss_state", 32'(state), (lim == DMAX) ? 2 : 1);
        end
    endtask

    task automatic run_pattern(input int c);
        int d;
        int n;
        int hi_n;
        int lo_n;
        int both_n;
        d = c + 512;
        apply_stimulus(1'b1, c, 1'b0, 1'b0);
        wait_ps(n);
        check_output("pat_duty", 32'(duty), d);
        wait_ps(n);
        check_output("pat_period", n, PERIOD);
        hi_n   = 0;
        lo_n   = 0;
        both_n = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            hi_n   += int'(pwm_hi);
            lo_n   += int'(pwm_lo);
            both_n += int'(pwm_hi & pwm_lo);
        end
        check_output("pat_hi_width", hi_n, max0(d - DEAD_TIME));
        check_output("pat_lo_width", lo_n, (d == 0) ? PERIOD : max0(PERIOD - d - DEAD_TIME));
        check_output("pat_overlap", both_n, 0);
    endtask

    initial begin
        int n;
        int r1;
        int r2;
        int r3;
        r1 = int'($urandom_range(1023, 0)) - 512;
        r2 = int'($urandom_range(1023, 0)) - 512;
        r3 = int'($urandom_range(1023, 0)) - 512;

        reset = 1'b1;
        apply_stimulus(1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_output("rst_hi", 32'(pwm_hi), 0);
        check_output("rst_lo", 32'(pwm_lo), 0);
        check_output("rst_ps", 32'(period_start), 0);
        check_output("rst_duty", 32'(duty), 0);
        check_output("rst_state", 32'(state), 0);
        check_output("rst_fault", 32'(fault_latched), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("idle_state", 32'(state), 0);
        check_output("idle_lo", 32'(pwm_lo), 0);

        $display("[TB] soft-start from IDLE");
        apply_stimulus(1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("ss_entry", 32'(state), 1);
        run_softstart(512);

        $display("[TB] RUN duty patterns");
        run_pattern(0);
        run_pattern(511);
        run_pattern(-512);
        run_pattern(-511);
        run_pattern(r1);
        run_pattern(r2);

        $display("[TB] mid-period ctrl step");
        apply_stimulus(1'b1, 0, 1'b0, 1'b0);
        wait_ps(n);
        check_output("step_pre_duty", 32'(duty), 512);
        repeat (300) @(negedge clk);
        apply_stimulus(1'b1, 100, 1'b0, 1'b0);
        @(negedge clk);
        check_output("step_hold", 32'(duty), 512);
        wait_ps(n);
        check_output("step_latency", n, PERIOD - 301);
        check_output("step_duty", 32'(duty), 612);

        $display("[TB] fault shutdown and recovery");
        repeat (100) @(negedge clk);
        check_output("flt_pre_hi", 32'(pwm_hi), 1);
        apply_stimulus(1'b1, 100, 1'b1, 1'b0);
        #1;
        check_output("flt_gate_hi", 32'(pwm_hi), 0);
        check_output("flt_gate_lo", 32'(pwm_lo), 0);
        check_output("flt_same_state", 32'(state), 2);
        @(negedge clk);
        check_output("flt_state", 32'(state), 3);
        check_output("flt_latched", 32'(fault_latched), 1);
        check_output("flt_duty", 32'(duty), 0);
        apply_stimulus(1'b1, 100, 1'b0, 1'b0);
        @(negedge clk);
        check_output("flt_hold", 32'(state), 3);
        apply_stimulus(1'b1, 100, 1'b0, 1'b1);
        @(negedge clk);
        check_output("flt_clr_state", 32'(state), 0);
        check_output("flt_clr_latched", 32'(fault_latched), 0);
        apply_stimulus(1'b1, 100, 1'b0, 1'b0);
        @(negedge clk);
        check_output("flt_reentry", 32'(state), 1);
        wait_ps(n);
        check_output("flt_ss_period", n, PERIOD);
        check_output("flt_ss_duty", 32'(duty), min2(612, SS_STEP));

        $display("[TB] enable drop");
        repeat (50) @(negedge clk);
        check_output("en_pre_hi", 32'(pwm_hi), 1);
        apply_stimulus(1'b0, 100, 1'b0, 1'b0);
        #1;
        check_output("en_gate_hi", 32'(pwm_hi), 0);
        check_output("en_gate_lo", 32'(pwm_lo), 0);
        @(negedge clk);
        check_output("en_state", 32'(state), 0);
        check_output("en_duty", 32'(duty), 0);

        $display("[TB] async reset in RUN");
        apply_stimulus(1'b1, r3, 1'b0, 1'b0);
        @(negedge clk);
        check_output("rs_entry", 32'(state), 1);
        run_softstart(r3 + 512);
        repeat ($urandom_range(1000, 10)) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check_output("arst_hi", 32'(pwm_hi), 0);
        check_output("arst_lo", 32'(pwm_lo), 0);
        check_output("arst_ps", 32'(period_start), 0);
        check_output("arst_duty", 32'(duty), 0);
        check_output("arst_state", 32'(state), 0);
        check_output("arst_fault", 32'(fault_latched), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
